// File: rtl/lm07_responder.sv
// LM07 temperature-sensor SPI responder: serialises {sign, clamped magnitude, status} MSB first per CS-low window.
// Optional build macro LM07_SWEEP_EN replaces the external temperature with an internal 0..99 sweep counter.
module lm07_responder #(
    parameter logic [7:0] STATUS_BYTE = 8'h0F,
    parameter logic [6:0] MAX_MAG     = 7'd99
) (
    input  logic       SYSCLK,
    input  logic       RSTN,
    input  logic       CS,
    input  logic       SCK,
    input  logic       TEMP_SIGN,
    input  logic [6:0] TEMP_MAG,
    output logic       SIO,
    output logic       SIO_OE,
    output logic       BUSY,
    output logic       FRAME_DONE,
    output logic [4:0] BIT_COUNT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_OVER
    } state_e;

    localparam logic [4:0] FRAME_BITS = 5'd16;

    logic        cs_meta_q, cs_sync_q, cs_dly_q;
    logic        sck_meta_q, sck_sync_q, sck_dly_q;
    logic        cs_fall_d, cs_fall_q, cs_rise_d, cs_rise_q;
    logic        sck_fall_d, sck_fall_q, sck_rise_d, sck_rise_q;

    logic        snap_sign_d, snap_sign_q;
    logic [6:0]  snap_mag_d, snap_mag_q;
    logic        src_sign;
    logic [6:0]  src_mag;
    logic [6:0]  clamped_mag;
    logic [15:0] frame;

    state_e      state_d, state_q;
    logic [15:0] shift_d, shift_q;
    logic [4:0]  bit_count_d, bit_count_q;
    logic        sio_d, sio_q;
    logic        sio_oe_d, sio_oe_q;
    logic        busy_d, busy_q;
    logic        frame_done_d, frame_done_q;

`ifdef LM07_SWEEP_EN
    localparam logic [6:0] SWEEP_LAST = 7'd99;

    logic [6:0] sweep_d, sweep_q;
    logic       unused_temp_inputs;

    // External temperature has no effect in the sweep build.
    assign unused_temp_inputs = ^{TEMP_SIGN, TEMP_MAG};
    assign src_sign = 1'b0;
    assign src_mag  = sweep_q;

    always_comb begin
        sweep_d = sweep_q;
        if (frame_done_d) begin
            sweep_d = (sweep_q == SWEEP_LAST) ? 7'd0 : sweep_q + 7'd1;
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            sweep_q <= 7'd0;
        end else begin
            sweep_q <= sweep_d;
        end
    end
`else
    assign src_sign = TEMP_SIGN;
    assign src_mag  = TEMP_MAG;
`endif

    assign clamped_mag = (snap_mag_q > MAX_MAG) ? MAX_MAG : snap_mag_q;
    assign frame       = {snap_sign_q, clamped_mag, STATUS_BYTE};

    // Edge detects are registered so every decision sees a clean one-cycle pulse.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cs_fall_d   = cs_dly_q & ~cs_sync_q;
        cs_rise_d   = ~cs_dly_q & cs_sync_q;
        sck_fall_d  = sck_dly_q & ~sck_sync_q;
        sck_rise_d  = ~sck_dly_q & sck_sync_q;
        snap_sign_d = snap_sign_q;
        snap_mag_d  = snap_mag_q;
        if (cs_fall_d) begin
            snap_sign_d = src_sign;
            snap_mag_d  = src_mag;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_count_d  = bit_count_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall_q) begin
                    state_d     = ST_SHIFT;
                    shift_d     = frame;
                    bit_count_d = 5'd0;
                end
            end
            ST_SHIFT: begin
                // CS rise takes priority: a coincident SCK edge is dropped.
                if (cs_rise_q) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end else if (sck_rise_q) begin
                    if (bit_count_q != FRAME_BITS) begin
                        bit_count_d = bit_count_q + 5'd1;
                    end
                end else if (sck_fall_q) begin
                    shift_d = {shift_q[14:0], 1'b0};
                    if (bit_count_q == FRAME_BITS) begin
                        state_d = ST_OVER;
                    end
                end
            end
            ST_OVER: begin
                if (cs_rise_q) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sio_d    = (state_d == ST_SHIFT) && shift_d[15];
        sio_oe_d = (state_d != ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            cs_meta_q    <= 1'b1;
            cs_sync_q    <= 1'b1;
            cs_dly_q     <= 1'b1;
            sck_meta_q   <= 1'b0;
            sck_sync_q   <= 1'b0;
            sck_dly_q    <= 1'b0;
            cs_fall_q    <= 1'b0;
            cs_rise_q    <= 1'b0;
            sck_fall_q   <= 1'b0;
            sck_rise_q   <= 1'b0;
            snap_sign_q  <= 1'b0;
            snap_mag_q   <= 7'd0;
            state_q      <= ST_IDLE;
            shift_q      <= 16'd0;
            bit_count_q  <= 5'd0;
            sio_q        <= 1'b0;
            sio_oe_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep the synchroniser chain a true shift register.
            cs_meta_q    <= CS;
            cs_sync_q    <= cs_meta_q;
            cs_dly_q     <= cs_sync_q;
            sck_meta_q   <= SCK;
            sck_sync_q   <= sck_meta_q;
            sck_dly_q    <= sck_sync_q;
            cs_fall_q    <= cs_fall_d;
            cs_rise_q    <= cs_rise_d;
            sck_fall_q   <= sck_fall_d;
            sck_rise_q   <= sck_rise_d;
            snap_sign_q  <= snap_sign_d;
            snap_mag_q   <= snap_mag_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_count_q  <= bit_count_d;
            sio_q        <= sio_d;
            sio_oe_q     <= sio_oe_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SIO        = sio_q;
    assign SIO_OE     = sio_oe_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = frame_done_q;
    assign BIT_COUNT  = bit_count_q;

endmodule

// File: tb/tb_lm07_responder.sv
// Self-checking bench for lm07_responder: a bit-banged SPI master with a scoreboard of expected received words.
module tb_lm07_responder;

    logic       SYSCLK = 1'b0;
    logic       RSTN;
    logic       CS;
    logic       SCK;
    logic       TEMP_SIGN;
    logic [6:0] TEMP_MAG;
    logic       SIO;
    logic       SIO_OE;
    logic       BUSY;
    logic       FRAME_DONE;
    logic [4:0] BIT_COUNT;

    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    logic [31:0] rx_word;
    logic [31:0] exp_q[$];

    lm07_responder dut (
        .SYSCLK    (SYSCLK),
        .RSTN      (RSTN),
        .CS        (CS),
        .SCK       (SCK),
        .TEMP_SIGN (TEMP_SIGN),
        .TEMP_MAG  (TEMP_MAG),
        .SIO       (SIO),
        .SIO_OE    (SIO_OE),
        .BUSY      (BUSY),
        .FRAME_DONE(FRAME_DONE),
        .BIT_COUNT (BIT_COUNT)
    );

    always #5 SYSCLK = ~SYSCLK;

    always @(negedge SYSCLK) begin
        if (FRAME_DONE === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_frame(input logic s, input logic [6:0] m);
        logic [6:0] c;
        c = (m > 7'd99) ? 7'd99 : m;
        return {s, c, 8'h0F};
    endfunction

    // Bits the master sees on SCK rises: frame MSB first, zeros once the 16 bits are spent.
    function automatic logic [31:0] model_rx(input logic [15:0] f, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[30:0], (i < 16) ? f[15 - i] : 1'b0};
        return r;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic start_frame(input logic msb);
        @(negedge SYSCLK);
        CS      = 1'b0;
        rx_word = '0;
        wait_cycles(4);
        check("sio_oe_at_start", SIO_OE, 1'b1);
        check("msb_at_start", SIO, msb);
        wait_cycles(1);
    endtask

    task automatic clock_bits(input int n, input int change_at, input logic [6:0] new_mag);
        for (int i = 0; i < n; i++) begin
            rx_word = {rx_word[30:0], SIO};
            SCK = 1'b1;
            wait_cycles(5);
            if (i == change_at) TEMP_MAG = new_mag;
            SCK = 1'b0;
            wait_cycles(5);
        end
    endtask

    task automatic compare_rx(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            check(tag, rx_word, exp_q.pop_front());
        end
    endtask

    task automatic end_frame(input logic [4:0] exp_bits);
        int lat;
        lat = 0;
        CS  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge SYSCLK);
            if (FRAME_DONE === 1'b1) begin
                lat = k;
                break;
            end
        end
        exp_done++;
        check("frame_done_latency", lat, 4);
        @(negedge SYSCLK);
        check("frame_done_width", FRAME_DONE, 1'b0);
        check("bit_count_after", BIT_COUNT, exp_bits);
        check("busy_after", BUSY, 1'b0);
        check("sio_oe_after", SIO_OE, 1'b0);
        wait_cycles(3);
    endtask

    initial begin
        RSTN      = 1'b0;
        CS        = 1'b1;
        SCK       = 1'b0;
        TEMP_SIGN = 1'b0;
        TEMP_MAG  = 7'd25;
        wait_cycles(3);
        RSTN = 1'b1;
        wait_cycles(10);
        check("reset_sio", SIO, 1'b0);
        check("reset_sio_oe", SIO_OE, 1'b0);
        check("reset_busy", BUSY, 1'b0);
        check("reset_bit_count", BIT_COUNT, 5'd0);
        check("reset_no_done", done_cnt, 0);

`ifdef LM07_SWEEP_EN
        TEMP_SIGN = 1'b1;
        TEMP_MAG  = 7'd55;
        for (int f = 0; f <= 100; f++) begin
            exp_q.push_back(model_rx(model_frame(1'b0, 7'(f % 100)), 8));
            start_frame(1'b0);
            clock_bits(8, -1, 7'd0);
            compare_rx("sweep_rx");
            end_frame(5'd8);
        end
`else
        // SCK activity with CS high must not count.
        clock_bits(3, -1, 7'd0);
        check("idle_sck_ignored", BIT_COUNT, 5'd0);
        check("idle_sck_no_oe", SIO_OE, 1'b0);

        // Full frame, positive 25 degrees.
        TEMP_SIGN = 1'b0;
        TEMP_MAG  = 7'd25;
        exp_q.push_back(model_rx(model_frame(1'b0, 7'd25), 16));
        start_frame(1'b0);
        clock_bits(16, -1, 7'd0);
        compare_rx("full_frame_rx");
        check("full_frame_bits", BIT_COUNT, 5'd16);
        end_frame(5'd16);

        // Clamp and sign, then over-clocking in OVER.
        TEMP_SIGN = 1'b1;
        TEMP_MAG  = 7'd120;
        exp_q.push_back(model_rx(model_frame(1'b1, 7'd120), 20));
        start_frame(1'b1);
        clock_bits(16, -1, 7'd0);
        check("over_busy", BUSY, 1'b1);
        check("over_sio_oe", SIO_OE, 1'b1);
        check("over_sio", SIO, 1'b0);
        check("over_bits_16", BIT_COUNT, 5'd16);
        clock_bits(4, -1, 7'd0);
        compare_rx("clamp_rx");
        check("over_bits_sat", BIT_COUNT, 5'd16);
        end_frame(5'd16);

        // Short frame with the input changing mid-frame; the snapshot must hold.
        TEMP_SIGN = 1'b0;
        TEMP_MAG  = 7'd42;
        exp_q.push_back(model_rx(model_frame(1'b0, 7'd42), 9));
        start_frame(1'b0);
        clock_bits(9, 3, 7'd7);
        compare_rx("short_rx");
        end_frame(5'd9);

        exp_q.push_back(model_rx(model_frame(1'b0, 7'd7), 16));
        start_frame(1'b0);
        clock_bits(16, -1, 7'd0);
        compare_rx("after_snapshot_rx");
        end_frame(5'd16);

        // Reset mid-frame.
        TEMP_MAG = 7'd25;
        start_frame(1'b0);
        clock_bits(5, -1, 7'd0);
        RSTN = 1'b0;
        #1;
        check("abort_sio_oe", SIO_OE, 1'b0);
        check("abort_bit_count", BIT_COUNT, 5'd0);
        check("abort_busy", BUSY, 1'b0);
        check("abort_sio", SIO, 1'b0);
        @(negedge SYSCLK);
        CS = 1'b1;
        wait_cycles(3);
        RSTN = 1'b1;
        wait_cycles(8);
        check("abort_no_done", done_cnt, exp_done);
        check("abort_idle", BUSY, 1'b0);

        exp_q.push_back(model_rx(model_frame(1'b0, 7'd25), 16));
        start_frame(1'b0);
        clock_bits(16, -1, 7'd0);
        compare_rx("post_abort_rx");
        end_frame(5'd16);
`endif

        check("frame_done_total", done_cnt, exp_done);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
